// File: rtl/irda_rx_framer.sv
// Receive framer for a demodulated IrDA SIR line, oversampled OSR times per bit.
// Define IRDA_RX_PARITY_EN to add a parity bit between the data and stop bits.
module irda_rx_framer #(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              tick,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int SCNT_W = $clog2(OSR);
  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [SCNT_W-1:0] MID_CNT  = SCNT_W'(OSR / 2 - 1);
  localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(OSR - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] LAST_STP = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef IRDA_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  function automatic logic expected_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t              state, state_nxt;
  logic [SCNT_W-1:0]   scnt, scnt_nxt;
  logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                fe, fe_nxt;
  logic                fin, fin_nxt;
  logic                valid_nxt, ferr_nxt;
  logic                step;
`ifdef IRDA_RX_PARITY_EN
  logic                pe, pe_nxt;
  logic                perr_nxt;
`endif

  assign step = ena & tick;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    data_nxt  = data;
    fe_nxt    = fe;
    fin_nxt   = fin;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef IRDA_RX_PARITY_EN
    pe_nxt    = pe;
    perr_nxt  = 1'b0;
`endif
    // fin marks a completed last stop sample; its result is issued on the next enabled clk
    if (ena && fin) begin
      fin_nxt   = 1'b0;
      fe_nxt    = 1'b0;
      scnt_nxt  = '0;
      bcnt_nxt  = '0;
      state_nxt = IDLE;
      if (fe) begin
        ferr_nxt = 1'b1;
      end else begin
        valid_nxt = 1'b1;
        data_nxt  = shreg;
`ifdef IRDA_RX_PARITY_EN
        perr_nxt  = pe;
`endif
      end
`ifdef IRDA_RX_PARITY_EN
      pe_nxt = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (step && !rxd) begin
            state_nxt = START;
            scnt_nxt  = '0;
          end
        end
        START: begin
          if (step) begin
            if (scnt == MID_CNT) begin
              scnt_nxt  = '0;
              bcnt_nxt  = '0;
              state_nxt = rxd ? IDLE : DATA;
            end else begin
              scnt_nxt = scnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (step) begin
            if (scnt == LAST_CNT) begin
              scnt_nxt  = '0;
              shreg_nxt = {rxd, shreg[DATA_W-1:1]};
              if (bcnt == LAST_BIT) begin
                bcnt_nxt  = '0;
`ifdef IRDA_RX_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end else begin
                bcnt_nxt = bcnt + 1'b1;
              end
            end else begin
              scnt_nxt = scnt + 1'b1;
            end
          end
        end
`ifdef IRDA_RX_PARITY_EN
        PARITY: begin
          if (step) begin
            if (scnt == LAST_CNT) begin
              scnt_nxt  = '0;
              pe_nxt    = (rxd != expected_parity(shreg));
              state_nxt = STOP;
            end else begin
              scnt_nxt = scnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          // a low level here never restarts reception; only IDLE looks for start bits
          if (step && !fin) begin
            if (scnt == LAST_CNT) begin
              scnt_nxt = '0;
              if (!rxd) fe_nxt = 1'b1;
              if (bcnt == LAST_STP) begin
                bcnt_nxt = '0;
                fin_nxt  = 1'b1;
              end else begin
                bcnt_nxt = bcnt + 1'b1;
              end
            end else begin
              scnt_nxt = scnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          scnt_nxt  = '0;
          bcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      data      <= '0;
      fe        <= 1'b0;
      fin       <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      scnt      <= scnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      fe        <= fe_nxt;
      fin       <= fin_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

`ifdef IRDA_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe         <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      pe         <= pe_nxt;
      parity_err <= perr_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_irda_rx_framer.sv
// Directed bench for irda_rx_framer (DATA_W=8, OSR=16, STOP_BITS=1); parity cases when IRDA_RX_PARITY_EN is defined.
module tb_irda_rx_framer;

  localparam int OSR = 16;
`ifdef IRDA_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       tick = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nvalid   = 0;
  int nferr    = 0;
  int nperr    = 0;
  int nbusy    = 0;
  int last_valid_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  int tick_div = 1;
  int tick_ph  = 0;

  irda_rx_framer #(.DATA_W(8), .OSR(OSR), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .tick(tick), .rxd(rxd),
    .data(data), .valid(valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      last_valid_cyc = cyc;
      last_data = data;
      last_perr = parity_err;
    end
    if (frame_err) nferr++;
    if (parity_err) nperr++;
    if (busy) nbusy++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step(input logic v);
    rxd  = v;
    tick = (tick_ph == 0);
    tick_ph = (tick_ph + 1) % tick_div;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v,
                            input int pause_bit, output int sc);
    tick_ph = 0;
    sc = cyc + 1;
    repeat (OSR * tick_div) clk_step(1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < OSR * tick_div; j++) begin
        if (i == pause_bit && j == 5) begin
          ena = 1'b0;
          repeat (50) @(negedge clk);
          ena = 1'b1;
        end
        clk_step(d[i]);
      end
    end
    if (PAR_EN) repeat (OSR * tick_div) clk_step(par);
    repeat (OSR * tick_div) clk_step(stop_v);
    repeat (4 * OSR * tick_div) clk_step(1'b1);
  endtask

  initial begin
    int v0, f0, p0, b0, sc, d_ref, d_pause;

    // asynchronous reset, no clock edge needed
    #2 rst = 1'b0;
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) clk_step(1'b1);

    // good frame 0xA5
    v0 = nvalid; f0 = nferr; p0 = nperr;
    send_frame(8'hA5, ^8'hA5, 1'b1, -1, sc);
    chk("a5_valid_count", nvalid - v0, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_frame_err", nferr - f0, 0);
    chk("a5_parity_err", nperr - p0, 0);

    // start glitch: 4 low ticks then high
    v0 = nvalid; f0 = nferr; b0 = nbusy;
    repeat (4) clk_step(1'b0);
    repeat (40) clk_step(1'b1);
    chk("glitch_busy_bounded", ((nbusy - b0) >= 1 && (nbusy - b0) <= 8), 1);
    chk("glitch_no_valid", nvalid - v0, 0);
    chk("glitch_no_ferr", nferr - f0, 0);
    chk("glitch_idle", busy, 0);

    // 0x3C with stop bit low
    v0 = nvalid; f0 = nferr; p0 = nperr;
    send_frame(8'h3C, ^8'h3C, 1'b0, -1, sc);
    chk("ferr_pulse", nferr - f0, 1);
    chk("ferr_no_valid", nvalid - v0, 0);
    chk("ferr_data_kept", data, 8'hA5);
    chk("ferr_no_perr", nperr - p0, 0);

`ifdef IRDA_RX_PARITY_EN
    // 0x07 with wrong even-parity bit
    v0 = nvalid;
    send_frame(8'h07, 1'b0, 1'b1, -1, sc);
    chk("par_valid_count", nvalid - v0, 1);
    chk("par_data", last_data, 8'h07);
    chk("par_err_same_clk", last_perr, 1);
`else
    chk("perr_never_seen", nperr, 0);
`endif

    // reference timing, then the same frame shape with a 50-clk ena freeze in bit 3
    send_frame(8'h96, ^8'h96, 1'b1, -1, sc);
    d_ref = last_valid_cyc - sc;
    chk("ref_data", last_data, 8'h96);
    v0 = nvalid;
    send_frame(8'hC3, ^8'hC3, 1'b1, 3, sc);
    d_pause = last_valid_cyc - sc;
    chk("pause_valid_count", nvalid - v0, 1);
    chk("pause_data", last_data, 8'hC3);
    chk("pause_delay", d_pause - d_ref, 50);

    // ticks on every other clk: counters must hold on tick=0
    tick_div = 2;
    v0 = nvalid;
    send_frame(8'h69, ^8'h69, 1'b1, -1, sc);
    tick_div = 1;
    chk("halfrate_valid_count", nvalid - v0, 1);
    chk("halfrate_data", last_data, 8'h69);

    // reset after 3 data bits of a frame
    tick_ph = 0;
    repeat (OSR) clk_step(1'b0);
    repeat (OSR) clk_step(1'b1);
    repeat (OSR) clk_step(1'b1);
    repeat (OSR) clk_step(1'b0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_data", data, 8'h00);
    chk("midrst_valid", valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_parity_err", parity_err, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) clk_step(1'b1);
    v0 = nvalid; f0 = nferr;
    send_frame(8'h5A, ^8'h5A, 1'b1, -1, sc);
    chk("post_rst_valid_count", nvalid - v0, 1);
    chk("post_rst_data", data, 8'h5A);
    chk("post_rst_no_ferr", nferr - f0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
